// File: rtl/rr_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_pkg
//  Description : Shared defaults and helpers for the round-robin 16-to-1
//                collector (rr_mux_16to1) and its arbiter (rr_arbiter).
//                DATA_W : per-channel data width
//                N_SRC  : number of source channels (power of two, 2..16)
//                SEL_W  : log2(N_SRC), width of a source index
//                onehot_to_idx() : one-hot grant vector -> binary index
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_pkg;

    localparam int DATA_W = 16;
    localparam int N_SRC  = 16;
    localparam int SEL_W  = 4;

    // OR-reduction encoder: for a true one-hot input only one index
    // contributes, so no priority chain is needed.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_SRC-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (oh[i]) begin
                idx = idx | i[SEL_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage : rr_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches req upwards
//                from index ptr, wrapping N_SRC-1 -> 0, and grants the first
//                requester found.
//  Ports       : req     [N_SRC] in  - request vector
//                ptr     [SEL_W] in  - highest-priority index this cycle
//                en              in  - grant enable (no grant when low)
//                gnt     [N_SRC] out - one-hot grant (zero when !en or !any)
//                gnt_idx [SEL_W] out - binary index of gnt
//                any             out - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_SRC = rr_mux_pkg::N_SRC,
    parameter int SEL_W = rr_mux_pkg::SEL_W
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_SRC-1:0] gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);
    import rr_mux_pkg::*;

    localparam int c_DBL_W = 2 * N_SRC;

    logic [N_SRC-1:0]                w_masked;
    logic [c_DBL_W-1:0]              w_dbl;
    logic [SEL_W-1:0]                w_win;
    logic [N_SRC-1:0]                w_onehot;
    logic [rr_mux_pkg::N_SRC-1:0]    w_onehot_ext;
    logic [rr_mux_pkg::SEL_W-1:0]    w_idx_full;

    // Lower copy keeps only requests at or above ptr; upper copy is the
    // unmasked vector, so a plain lowest-set-bit search over the doubled
    // vector yields the wrap-around round-robin winner.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_mask
        assign w_masked[gi] = req[gi] & (SEL_W'(gi) >= ptr);
    end

    assign w_dbl = {req, w_masked};
    assign any   = |req;

    always_comb begin
        w_win = '0;
        // Descending scan so the lowest set bit is the last one written.
        // N_SRC is a power of two, so the low SEL_W bits are the index
        // modulo N_SRC for both copies.
        for (int j = c_DBL_W - 1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                w_win = j[SEL_W-1:0];
            end
        end
    end

    assign w_onehot = (en && any) ? (N_SRC'(1) << w_win) : '0;
    assign gnt      = w_onehot;

    always_comb begin
        w_onehot_ext               = '0;
        w_onehot_ext[N_SRC-1:0]    = w_onehot;
        w_idx_full                 = onehot_to_idx(w_onehot_ext);
    end

    assign gnt_idx = w_idx_full[SEL_W-1:0];

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rr_mux_16to1.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_16to1
//  Description : Round-robin N_SRC-to-1 collector. Each source offers a
//                DATA_W word with valid/ready; one source per cycle is
//                granted and its word lands in a single registered output
//                stage. Full throughput (drain and load on the same edge).
//  Ports       : clk                       in  - rising-edge clock
//                rst_n                     in  - synchronous active-low reset
//                in_valid  [N_SRC]         in  - per-source valid
//                in_data   [N_SRC*DATA_W]  in  - source i at [i*DATA_W +: DATA_W]
//                in_last   [N_SRC]         in  - burst end marker (lock build)
//                in_ready  [N_SRC]         out - one-hot grant
//                out_valid                 out - output register full
//                out_data  [DATA_W]        out - registered word
//                out_src   [SEL_W]         out - source of out_data
//                out_ready                 in  - consumer accept
//  Options     : RR_MUX_BURST_LOCK_EN - adds in_last; a granted source keeps
//                the grant until it delivers a word with in_last set.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_16to1 #(
    parameter int DATA_W = rr_mux_pkg::DATA_W,
    parameter int N_SRC  = rr_mux_pkg::N_SRC,
    parameter int SEL_W  = rr_mux_pkg::SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        in_valid,
    input  logic [N_SRC*DATA_W-1:0] in_data,
`ifdef RR_MUX_BURST_LOCK_EN
    input  logic [N_SRC-1:0]        in_last,
`endif
    output logic [N_SRC-1:0]        in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SEL_W-1:0]        out_src,
    input  logic                    out_ready
);
    import rr_mux_pkg::*;

    // Output stage and round-robin pointer
    logic              r_out_valid_q, w_out_valid_d;
    logic [DATA_W-1:0] r_out_data_q,  w_out_data_d;
    logic [SEL_W-1:0]  r_out_src_q,   w_out_src_d;
    logic [SEL_W-1:0]  r_ptr_q,       w_ptr_d;

    logic              w_can_load;
    logic              w_arb_en;
    logic              w_accept;
    logic              w_last;
    logic              w_any;
    logic [N_SRC-1:0]  w_req;
    logic [N_SRC-1:0]  w_gnt;
    logic [SEL_W-1:0]  w_gnt_idx;

    // The output register may take a new word when empty or when its
    // current word leaves on this same edge.
    assign w_can_load = ~r_out_valid_q | out_ready;
    // rst_n gates the grant so no source sees a handshake during reset.
    assign w_arb_en   = w_can_load & rst_n;
    assign w_accept   = w_any & w_arb_en;

`ifdef RR_MUX_BURST_LOCK_EN
    logic              r_lock_q,     w_lock_d;
    logic [SEL_W-1:0]  r_lock_idx_q, w_lock_idx_d;

    // While locked, only the burst owner may be granted.
    always_comb begin
        w_req = in_valid;
        if (r_lock_q) begin
            w_req = in_valid & (N_SRC'(1) << r_lock_idx_q);
        end
    end

    assign w_last = in_last[w_gnt_idx];

    always_comb begin
        w_lock_d     = r_lock_q;
        w_lock_idx_d = r_lock_idx_q;
        if (w_accept) begin
            w_lock_d     = ~w_last;
            w_lock_idx_d = w_gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock_q     <= 1'b0;
            r_lock_idx_q <= '0;
        end else begin
            r_lock_q     <= w_lock_d;
            r_lock_idx_q <= w_lock_idx_d;
        end
    end
`else
    assign w_req  = in_valid;
    // Without bursts every word closes its own transfer.
    assign w_last = 1'b1;
`endif

    rr_arbiter #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_ptr_q),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign in_ready = w_gnt;

    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_data_d  = r_out_data_q;
        w_out_src_d   = r_out_src_q;
        w_ptr_d       = r_ptr_q;
        if (w_accept) begin
            w_out_valid_d = 1'b1;
            w_out_data_d  = in_data[w_gnt_idx*DATA_W +: DATA_W];
            w_out_src_d   = w_gnt_idx;
            // Pointer moves past the winner only when its transfer ends;
            // the SEL_W-bit add wraps N_SRC-1 -> 0 on its own.
            if (w_last) begin
                w_ptr_d = w_gnt_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            // Drain with nothing to refill: data/src keep last values.
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_out_src_q   <= '0;
            r_ptr_q       <= '0;
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_out_src_q   <= w_out_src_d;
            r_ptr_q       <= w_ptr_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;
    assign out_src   = r_out_src_q;

endmodule : rr_mux_16to1
`default_nettype wire

// File: tb/tb_rr_mux_16to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_mux_16to1
//  Description : Self-checking bench for rr_mux_16to1. A behavioural model
//                (pointer walk with modulo arithmetic) predicts in_ready and
//                the output register every cycle; directed steps cover
//                reset, sweep, wrap, backpressure, drain and burst lock,
//                followed by a randomized run. RR_MUX_BURST_LOCK_EN enables
//                the burst-lock section.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_16to1;

    localparam int N = 16;
    localparam int W = 16;
    localparam int S = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
`ifdef RR_MUX_BURST_LOCK_EN
    logic [N-1:0]     in_last;
`endif
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [S-1:0]     out_src;
    logic             out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_ptr;
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_src;
    bit         m_lock;
    int         m_lock_idx;
    int         m_g;

    rr_mux_16to1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX_BURST_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [W-1:0] v);
        in_data[idx*W +: W] = v;
    endtask

    function automatic int model_grant();
        int idx;
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        if (m_lock) return in_valid[m_lock_idx] ? m_lock_idx : -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit model_last(input int g);
`ifdef RR_MUX_BURST_LOCK_EN
        return in_last[g];
`else
        return (g >= 0);
`endif
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_lock = 0; m_lock_idx = 0;
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        #1;
        m_g     = model_grant();
        exp_rdy = (m_g >= 0) ? (N'(1) << m_g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (m_g >= 0) begin
            m_valid = 1;
            m_data  = in_data[m_g*W +: W];
            m_src   = m_g;
            if (model_last(m_g)) begin
                m_ptr  = (m_g + 1) % N;
                m_lock = 0;
            end else begin
                m_lock     = 1;
                m_lock_idx = m_g;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_src",   32'(out_src),   32'(m_src));
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, W'(16'hA000 + i));
`ifdef RR_MUX_BURST_LOCK_EN
        in_last = '1;
`endif
        @(posedge clk);
        @(negedge clk);

        // Reset held with every source valid
        cycle();
        cycle();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_src",  32'(out_src),  32'h0);

        // Release: first grant goes to source 0, then a bubble-free sweep
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(in_ready), 32'h1);
        for (int k = 0; k < 17; k++) begin
            cycle();
            chk("sweep_src",   32'(out_src),   32'(k % N));
            chk("sweep_data",  32'(out_data),  32'(16'hA000 + (k % N)));
            chk("sweep_valid", 32'(out_valid), 32'h1);
        end

        // Sparse wrap: park pointer at 14, then only 3 and 15 valid
        in_valid = N'(1) << 13;
        cycle();
        in_valid = (N'(1) << 3) | (N'(1) << 15);
        cycle();
        chk("wrap_first",  32'(out_src), 32'd15);
        cycle();
        chk("wrap_second", 32'(out_src), 32'd3);
        in_valid = '1;
        #1;
        chk("wrap_ptr4", 32'(in_ready), 32'h0010);
        cycle();

        // Backpressure around a word from source 2
        set_data(2, 16'h1234);
        in_valid = N'(1) << 2;
        cycle();
        chk("bp_load_src", 32'(out_src), 32'd2);
        in_valid  = (N'(1) << 2) | (N'(1) << 9);
        out_ready = 1'b0;
        repeat (5) begin
            cycle();
            chk("bp_hold_data", 32'(out_data), 32'h1234);
            chk("bp_no_ready",  32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_next_src",   32'(out_src),   32'd9);
        chk("bp_next_valid", 32'(out_valid), 32'h1);

        // Drain to empty after a single word from source 7
        in_valid = N'(1) << 7;
        cycle();
        chk("drain_src", 32'(out_src), 32'd7);
        in_valid = '0;
        cycle();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_src_hold", 32'(out_src), 32'd7);

`ifdef RR_MUX_BURST_LOCK_EN
        // Source 5 bursts three words while source 6 waits
        in_valid = (N'(1) << 5) | (N'(1) << 6);
        in_last  = '0;
        cycle();
        chk("burst_w0", 32'(out_src), 32'd5);
        cycle();
        chk("burst_w1", 32'(out_src), 32'd5);
        in_last[5] = 1'b1;
        cycle();
        chk("burst_w2", 32'(out_src), 32'd5);
        cycle();
        chk("burst_next", 32'(out_src), 32'd6);
        // Source 6 holds a lock; reset mid-burst releases it
        rst_n = 1'b0;
        cycle();
        rst_n    = 1'b1;
        in_valid = (N'(1) << 0) | (N'(1) << 6);
        #1;
        chk("burst_rst_grant", 32'(in_ready), 32'h1);
        cycle();
        in_last = '1;
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       in_valid = '1;
                1:       in_valid = '0;
                default: in_valid = N'($urandom & $urandom);
            endcase
            for (int i = 0; i < N; i++) set_data(i, W'($urandom));
`ifdef RR_MUX_BURST_LOCK_EN
            in_last = N'($urandom | $urandom);
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 59) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_rr_mux_16to1
`default_nettype wire
